mpadder_ctrl: RTL and testbench

MPADDER_CTRL -- requirements
Module: mpadder_ctrl

---
 rtl/mpadder_pkg.sv | 14 +
 rtl/rr_arb2.sv | 37 +++
 rtl/mpadder_ctrl.sv | 99 +++++++++
 tb/tb_mpadder_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mpadder_pkg.sv
// Shared definitions for the multi-precision adder controller: FSM states and counter sizing.
package mpadder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    localparam int unsigned NCYCLES_DEFAULT = 9;
    localparam int unsigned CNT_W           = $clog2(64);

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter; round-robin by default, fixed priority to requester 0 when
// MPADDER_CTRL_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Set when requester 1 is favoured on contention.
    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
`ifdef MPADDER_CTRL_FIXED_PRIO_EN
            ptr_q <= 1'b0;
`else
            // Favour whichever requester did not just win.
            ptr_q <= gnt[0];
`endif
        end
    end

endmodule

// File: rtl/mpadder_ctrl.sv
// Sequencer for a bit-serial multi-precision adder shared by two requesters.
// Optional build macro: MPADDER_CTRL_FIXED_PRIO_EN (fixed priority to requester 0).
module mpadder_ctrl
    import mpadder_pkg::*;
#(
    parameter int unsigned NCYCLES = NCYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [1:0] sub_req,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       carry_out,
    output logic       busy,
    output logic       load,
    output logic       subtract,
    output logic       shift,
    output logic       enableC,
    input  logic       cZero
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NCYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       arb_gnt;
    logic             arb_advance;

    assign arb_advance = (state_q == StIdle) && (req != 2'b00);

    rr_arb2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    // All outputs are registered next to the state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gnt       <= 2'b00;
            done      <= 2'b00;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            load      <= 1'b0;
            subtract  <= 1'b0;
            shift     <= 1'b0;
            enableC   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req != 2'b00) begin
                        state_q  <= StLoad;
                        gnt      <= arb_gnt;
                        subtract <= |(arb_gnt & sub_req);
                        busy     <= 1'b1;
                        load     <= 1'b1;
                        enableC  <= 1'b1;
                    end
                end
                StLoad: begin
                    state_q <= StRun;
                    cnt_q   <= '0;
                    load    <= 1'b0;
                    shift   <= 1'b1;
                end
                StRun: begin
                    if (cnt_q == CntLast) begin
                        state_q   <= StDone;
                        shift     <= 1'b0;
                        enableC   <= 1'b0;
                        done      <= gnt;
                        carry_out <= ~cZero;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    cnt_q    <= '0;
                    done     <= 2'b00;
                    gnt      <= 2'b00;
                    busy     <= 1'b0;
                    subtract <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    gnt_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt));
    done_granted: assert property (@(posedge clk) disable iff (!resetn) (done & ~gnt) == 2'b00);
    load_shift_excl: assert property (@(posedge clk) disable iff (!resetn) !(load && shift));

endmodule

// File: tb/tb_mpadder_ctrl.sv
// Randomized bench for mpadder_ctrl: a transaction-level model predicts grants, timing and results.
module tb_mpadder_ctrl;

    localparam int N = 9;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] sub_req = 2'b00;
    logic       cZero = 1'b0;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       carry_out;
    logic       busy;
    logic       load;
    logic       subtract;
    logic       shift;
    logic       enableC;

    mpadder_ctrl #(.NCYCLES(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .sub_req   (sub_req),
        .gnt       (gnt),
        .done      (done),
        .carry_out (carry_out),
        .busy      (busy),
        .load      (load),
        .subtract  (subtract),
        .shift     (shift),
        .enableC   (enableC),
        .cZero     (cZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] d;
        logic       c;
        logic       s;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic czt[256];

    // Transaction model: an operation sampled at cycle t_start occupies cycles t_start+1..+N+2.
    logic       t_active = 1'b0;
    int         t_start = 0;
    logic [1:0] t_win = 2'b00;
    logic       t_sub = 1'b0;
    int         free_cyc = 0;
    logic       last_one = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] arbitrate(input logic [1:0] r);
        if (r != 2'b11) return r;
`ifdef MPADDER_CTRL_FIXED_PRIO_EN
        return 2'b01;
`else
        return last_one ? 2'b01 : 2'b10;
`endif
    endfunction

    task automatic step(input logic rst, input logic [1:0] r, input logic [1:0] s);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        resetn  = rst;
        req     = r;
        sub_req = s;
        cZero   = czt[cyc % 256];
        if (!rst) begin
            t_active = 1'b0;
            sbq.delete();
            free_cyc = 0;
            last_one = 1'b1;
        end else if (cyc >= free_cyc && r != 2'b00) begin
            t_win    = arbitrate(r);
            last_one = (t_win == 2'b10);
            t_sub    = |(t_win & s);
            t_start  = cyc;
            t_active = 1'b1;
            free_cyc = cyc + N + 3;
            e.cyc = cyc + N + 2;
            e.d   = t_win;
            e.c   = ~czt[(cyc + N + 1) % 256];
            e.s   = t_sub;
            sbq.push_back(e);
        end
    endtask

    // Monitor: per-cycle control checks plus scoreboard pop on every done pulse.
    logic [4:0] m_exp;
    logic       m_win;
    logic       m_load;
    logic       m_shift;
    exp_t       m_e;

    always @(negedge clk) begin
        if (!resetn) begin
            chk("reset_outputs",
                64'({gnt, done, carry_out, busy, load, subtract, shift, enableC}), 64'(0));
        end else begin
            m_win   = t_active && cyc >= t_start + 1 && cyc <= t_start + N + 2;
            m_load  = m_win && cyc == t_start + 1;
            m_shift = m_win && cyc >= t_start + 2 && cyc <= t_start + N + 1;
            m_exp   = m_win ? {t_win, 1'b1, m_load, m_shift} : 5'b0;
            chk("ctrl", 64'({gnt, busy, load, shift}), 64'(m_exp));
            chk("enableC", 64'(enableC), 64'(m_load | m_shift));
            if (m_win) chk("subtract", 64'(subtract), 64'(t_sub));
            if (done != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    m_e = sbq.pop_front();
                    chk("done", 64'({32'(cyc), done, carry_out, subtract}),
                        64'({32'(m_e.cyc), m_e.d, m_e.c, m_e.s}));
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                m_e = sbq.pop_front();
                chk("missing_done", 64'(done), 64'(m_e.d));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 4 * N && cyc < free_cyc; i++) step(1'b1, 2'b00, 2'b00);
        repeat (2) step(1'b1, 2'b00, 2'b00);
    endtask

    task automatic random_phase(input int ncyc);
        int r;
        for (int i = 0; i < ncyc; i++) begin
            r = $urandom_range(0, 5);
            step(1'b1, (r >= 4) ? 2'b00 : 2'(r), 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) czt[i] = 1'($urandom_range(0, 1));
        repeat (3) step(1'b0, 2'b00, 2'b00);

        // Contended start: requester 0 must win first, then alternate.
        repeat (3 * (N + 3)) step(1'b1, 2'b11, 2'b10);
        drain();
        random_phase(2500);
        drain();

        // Reset in the middle of RUN with the request held through it.
        step(1'b1, 2'b01, 2'b00);
        repeat (4) step(1'b1, 2'b01, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        #1;
        chk("reset_async",
            64'({gnt, done, carry_out, busy, load, subtract, shift, enableC}), 64'(0));
        repeat (2) step(1'b0, 2'b01, 2'b00);
        repeat (N + 6) step(1'b1, 2'b01, 2'b01);
        drain();

        random_phase(600);
        drain();
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
